// File: rtl/usart_pkg.sv
// Shared constants and state encodings for the USART frame receiver.
package usart_pkg;

  localparam logic [7:0] FRAME_HEAD = 8'hFF;
  localparam logic [7:0] FRAME_TAIL = 8'hAA;
  localparam int         FRAME_LEN  = 7;

  // Frame-level FSM: one state per byte position of the 7-byte frame.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_MODE,
    ST_D2,
    ST_D1,
    ST_D0,
    ST_TAIL
  } frame_state_e;

  // Byte-level receiver FSM.
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_recv.sv
// 8N1 byte receiver: synchronizes uart_rxd, detects the start edge, samples
// each bit at mid-bit and reports the byte or a framing error.
// Handshake: rx_valid and rx_ferr are single-cycle strobes with no
// backpressure; rx_byte is valid in (and held after) the rx_valid cycle.
module uart_recv
  import usart_pkg::*;
#(
  parameter logic [15:0] BPS_CNT = 16'd434
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       uart_rxd,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_ferr
);

  localparam logic [15:0] HALF_CNT = BPS_CNT >> 1;

  logic        rxd_meta_q, rxd_sync_q, rxd_prev_q;
  rx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  byte_q, byte_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        fall_edge;

  assign fall_edge = rxd_prev_q & ~rxd_sync_q;

  // Synchronizer and edge-detect flops reset high so an idle line never looks like a start.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      rxd_meta_q <= uart_rxd;
      rxd_sync_q <= rxd_meta_q;
      rxd_prev_q <= rxd_sync_q;
    end
  end

  // Receiver state, bit counters and registered strobes.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state: start re-check at half a bit, then sample every full bit period.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (fall_edge) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_CNT - 16'd1) begin
          cnt_d = '0;
          bit_d = '0;
          // A start bit that is high again at mid-bit was only a glitch.
          state_d = rxd_sync_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == BPS_CNT - 16'd1) begin
          cnt_d   = '0;
          shift_d = {rxd_sync_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == BPS_CNT - 16'd1) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (rxd_sync_q) begin
            valid_d = 1'b1;
            byte_d  = shift_q;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign rx_byte  = byte_q;
  assign rx_valid = valid_q;
  assign rx_ferr  = ferr_q;

endmodule

// File: rtl/usart_frame_recv.sv
// Frame receiver: parses FF/addr/mode/D2/D1/D0/AA frames from the byte
// receiver, shadows the fields and publishes them on a good trailer.
module usart_frame_recv
  import usart_pkg::*;
#(
  parameter logic [15:0] BPS_CNT     = 16'd434,
  parameter logic [15:0] TIMEOUT_CNT = 16'd12000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        uart_rxd,
  output logic        frame_valid,
  output logic [1:0]  Adress,
  output logic [5:0]  Mod_SEL,
  output logic [23:0] D,
  output logic        frame_err
);

  logic [7:0]   rx_byte;
  logic         rx_valid, rx_ferr;
  frame_state_e state_q, state_d;
  logic [15:0]  tmo_q, tmo_d;
  logic [1:0]   addr_sh_q, addr_sh_d, adr_q, adr_d;
  logic [5:0]   mode_sh_q, mode_sh_d, mode_q, mode_d;
  logic [23:0]  data_sh_q, data_sh_d, data_q, data_d;
  logic         fv_q, fv_d, fe_q, fe_d;
  logic         tmo_hit, abort;

  uart_recv #(.BPS_CNT(BPS_CNT)) u_recv (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .uart_rxd (uart_rxd),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .rx_ferr  (rx_ferr)
  );

  // tmo_q is zero in the first cycle after a byte, so it holds (cycles since
  // rx_valid) - 1; registering the abort at TIMEOUT_CNT-2 makes frame_err
  // appear exactly TIMEOUT_CNT cycles after the last rx_valid.
  assign tmo_hit = (state_q != ST_IDLE) && (tmo_q == TIMEOUT_CNT - 16'd2);

  // Frame state, shadows, published fields and pulses.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= ST_IDLE;
      tmo_q     <= '0;
      addr_sh_q <= '0;
      mode_sh_q <= '0;
      data_sh_q <= '0;
      adr_q     <= '0;
      mode_q    <= '0;
      data_q    <= '0;
      fv_q      <= 1'b0;
      fe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      addr_sh_q <= addr_sh_d;
      mode_sh_q <= mode_sh_d;
      data_sh_q <= data_sh_d;
      adr_q     <= adr_d;
      mode_q    <= mode_d;
      data_q    <= data_d;
      fv_q      <= fv_d;
      fe_q      <= fe_d;
    end
  end

  // Next-state: a received byte takes priority over a framing error or timeout.
  always_comb begin
    state_d   = state_q;
    tmo_d     = (state_q == ST_IDLE) ? 16'd0 : tmo_q + 16'd1;
    addr_sh_d = addr_sh_q;
    mode_sh_d = mode_sh_q;
    data_sh_d = data_sh_q;
    adr_d     = adr_q;
    mode_d    = mode_q;
    data_d    = data_q;
    fv_d      = 1'b0;
    abort     = 1'b0;
    if (rx_valid) begin
      tmo_d = '0;
      case (state_q)
        ST_IDLE: if (rx_byte == FRAME_HEAD) state_d = ST_ADDR;
        ST_ADDR: begin
          if (rx_byte[7:2] != 6'd0) abort = 1'b1;
          else begin
            addr_sh_d = rx_byte[1:0];
            state_d   = ST_MODE;
          end
        end
        ST_MODE: begin
          if (rx_byte[7:6] != 2'd0) abort = 1'b1;
          else begin
            mode_sh_d = rx_byte[5:0];
            state_d   = ST_D2;
          end
        end
        ST_D2: begin
          data_sh_d[23:16] = rx_byte;
          state_d          = ST_D1;
        end
        ST_D1: begin
          data_sh_d[15:8] = rx_byte;
          state_d         = ST_D0;
        end
        ST_D0: begin
          data_sh_d[7:0] = rx_byte;
          state_d        = ST_TAIL;
        end
        ST_TAIL: begin
          if (rx_byte == FRAME_TAIL) begin
            adr_d   = addr_sh_q;
            mode_d  = mode_sh_q;
            data_d  = data_sh_q;
            fv_d    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            abort = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE && (rx_ferr || tmo_hit)) begin
      abort = 1'b1;
    end
    if (abort) begin
      state_d = ST_IDLE;
      tmo_d   = '0;
    end
    fe_d = abort;
  end

  assign frame_valid = fv_q;
  assign frame_err   = fe_q;
  assign Adress      = adr_q;
  assign Mod_SEL     = mode_q;
  assign D           = data_q;

endmodule

// File: tb/tb_usart_frame_recv.sv
// Directed bench for usart_frame_recv: table of frames plus hand sequences
// for timeout, framing error, glitch and mid-frame reset.
module tb_usart_frame_recv;

  localparam logic [15:0] BPS_A = 16'd16;
  localparam logic [15:0] TMO_A = 16'd400;
  localparam int          BPS_B = 434;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        rxd_a, rxd_b;
  logic        fv_a, fe_a, fv_b, fe_b;
  logic [1:0]  adr_a, adr_b;
  logic [5:0]  mode_a, mode_b;
  logic [23:0] d_a, d_b;

  int n_vec = 0;
  int n_mis = 0;
  int fv_cnt = 0, fe_cnt = 0, fv_cnt_b = 0, fe_cnt_b = 0;
  int inv_bad = 0;
  int cyc = 0, last_rxv = 0, fe_cyc = 0;
  logic [31:0] prev_out;

  usart_frame_recv #(.BPS_CNT(BPS_A), .TIMEOUT_CNT(TMO_A)) dut_a (
    .sys_clk (sys_clk), .sys_rst (sys_rst), .uart_rxd (rxd_a),
    .frame_valid (fv_a), .Adress (adr_a), .Mod_SEL (mode_a), .D (d_a),
    .frame_err (fe_a)
  );

  usart_frame_recv dut_b (
    .sys_clk (sys_clk), .sys_rst (sys_rst), .uart_rxd (rxd_b),
    .frame_valid (fv_b), .Adress (adr_b), .Mod_SEL (mode_b), .D (d_b),
    .frame_err (fe_b)
  );

  // clock / cycle counter
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // pulse counters and invariants, sampled on the falling edge
  always @(negedge sys_clk) begin
    if (fv_a) fv_cnt <= fv_cnt + 1;
    if (fe_a) begin
      fe_cnt <= fe_cnt + 1;
      fe_cyc <= cyc;
    end
    if (fv_b) fv_cnt_b <= fv_cnt_b + 1;
    if (fe_b) fe_cnt_b <= fe_cnt_b + 1;
    if (dut_a.rx_valid) last_rxv <= cyc;
    if (fv_a && fe_a) begin
      inv_bad <= inv_bad + 1;
      $display("FAIL pulse_overlap at cycle %0d: frame_valid and frame_err both 1, required not both", cyc);
    end
    if (!sys_rst && !fv_a && ({adr_a, mode_a, d_a} !== prev_out)) begin
      inv_bad <= inv_bad + 1;
      $display("FAIL output_hold at cycle %0d: outputs %0h, required held at %0h", cyc, {adr_a, mode_a, d_a}, prev_out);
    end
    prev_out <= {adr_a, mode_a, d_a};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic v);
    if (sel == 0) rxd_a = v;
    else          rxd_b = v;
  endtask

  // one 8N1 character, LSB first, with a selectable stop-bit level
  task automatic send_byte(input int sel, input logic [7:0] b, input logic stop_bit);
    int bc;
    bc = (sel == 0) ? int'(BPS_A) : BPS_B;
    drive(sel, 1'b0);
    wait_cyc(bc);
    for (int i = 0; i < 8; i++) begin
      drive(sel, b[i]);
      wait_cyc(bc);
    end
    drive(sel, stop_bit);
    wait_cyc(bc);
    drive(sel, 1'b1);
  endtask

  typedef struct {
    logic [111:0] bs;   // first byte in bits [111:104]
    int           n;
    int           fv;
    int           fe;
    logic [1:0]   adr;
    logic [5:0]   mode;
    logic [23:0]  d;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int fv0, fe0, waited;
    logic [111:0] tmp;
    logic [7:0]   frm[7];

    vecs[0] = '{{8'hFF, 8'h02, 8'h15, 8'h12, 8'h34, 8'h56, 8'hAA, {7{8'h00}}}, 7, 1, 0, 2'd2, 6'h15, 24'h123456};
    vecs[1] = '{{8'h00, 8'h55, 8'hFF, 8'h01, 8'h3F, 8'hFF, 8'hAA, 8'hFF, 8'hAA, {5{8'h00}}}, 9, 1, 0, 2'd1, 6'h3F, 24'hFFAAFF};
    vecs[2] = '{{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'hAA, {7{8'h00}}}, 7, 1, 0, 2'd0, 6'h00, 24'h000001};
    vecs[3] = '{{8'hFF, 8'h01, 8'h01, 8'h00, 8'h00, 8'h02, 8'hAB, {7{8'h00}}}, 7, 0, 1, 2'd0, 6'h00, 24'h000001};
    vecs[4] = '{{8'hFF, 8'h04, {12{8'h00}}}, 2, 0, 1, 2'd0, 6'h00, 24'h000001};
    vecs[5] = '{{8'hFF, 8'h03, 8'h40, {11{8'h00}}}, 3, 0, 1, 2'd0, 6'h00, 24'h000001};
    vecs[6] = '{{8'hFF, 8'h03, 8'h3F, 8'hAB, 8'hCD, 8'hEF, 8'hAA, {7{8'h00}}}, 7, 1, 0, 2'd3, 6'h3F, 24'hABCDEF};
    vecs[7] = '{{8'hFF, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'hAA,
                 8'hFF, 8'h02, 8'h03, 8'h06, 8'h07, 8'h08, 8'hAA}, 14, 2, 0, 2'd2, 6'h03, 24'h060708};

    // reset
    sys_rst = 1'b1;
    rxd_a   = 1'b1;
    rxd_b   = 1'b1;
    wait_cyc(5);
    check("reset_outputs_a", {fv_a, fe_a, adr_a, mode_a, d_a}, 32'h0);
    check("reset_outputs_b", {fv_b, fe_b, adr_b, mode_b, d_b}, 32'h0);
    sys_rst = 1'b0;
    wait_cyc(20);

    // table of frames on the fast instance
    for (int v = 0; v < 8; v++) begin
      fv0 = fv_cnt;
      fe0 = fe_cnt;
      tmp = vecs[v].bs;
      for (int j = 0; j < vecs[v].n; j++) send_byte(0, tmp[111 - 8*j -: 8], 1'b1);
      wait_cyc(3 * int'(BPS_A));
      check($sformatf("vec%0d_valid_pulses", v), fv_cnt - fv0, vecs[v].fv);
      check($sformatf("vec%0d_err_pulses", v), fe_cnt - fe0, vecs[v].fe);
      check($sformatf("vec%0d_adress", v), adr_a, vecs[v].adr);
      check($sformatf("vec%0d_mod_sel", v), mode_a, vecs[v].mode);
      check($sformatf("vec%0d_d", v), d_a, vecs[v].d);
    end

    // inter-byte timeout after FF 01 01, then a good frame
    fv0 = fv_cnt;
    fe0 = fe_cnt;
    send_byte(0, 8'hFF, 1'b1);
    send_byte(0, 8'h01, 1'b1);
    send_byte(0, 8'h01, 1'b1);
    waited = 0;
    while (fe_cnt == fe0 && waited < 1000) begin
      wait_cyc(1);
      waited++;
    end
    wait_cyc(20);
    check("tmo_err_pulses", fe_cnt - fe0, 1);
    check("tmo_latency", fe_cyc - last_rxv, int'(TMO_A));
    check("tmo_no_valid", fv_cnt - fv0, 0);
    frm = '{8'hFF, 8'h02, 8'h01, 8'hAB, 8'hCD, 8'hEF, 8'hAA};
    for (int j = 0; j < 7; j++) send_byte(0, frm[j], 1'b1);
    wait_cyc(48);
    check("post_tmo_valid", fv_cnt - fv0, 1);
    check("post_tmo_fields", {adr_a, mode_a, d_a}, {2'd2, 6'h01, 24'hABCDEF});

    // stop bit low on the D1 byte
    fv0 = fv_cnt;
    fe0 = fe_cnt;
    send_byte(0, 8'hFF, 1'b1);
    send_byte(0, 8'h01, 1'b1);
    send_byte(0, 8'h01, 1'b1);
    send_byte(0, 8'h12, 1'b1);
    send_byte(0, 8'h34, 1'b0);
    wait_cyc(48);
    check("ferr_err_pulses", fe_cnt - fe0, 1);
    check("ferr_no_valid", fv_cnt - fv0, 0);
    check("ferr_fields_held", {adr_a, mode_a, d_a}, {2'd2, 6'h01, 24'hABCDEF});

    // 0.3-bit glitches on the idle line, in IDLE and between frame bytes
    fv0 = fv_cnt;
    fe0 = fe_cnt;
    rxd_a = 1'b0; wait_cyc(5); rxd_a = 1'b1; wait_cyc(40);
    send_byte(0, 8'hFF, 1'b1);
    send_byte(0, 8'h01, 1'b1);
    send_byte(0, 8'h01, 1'b1);
    wait_cyc(10);
    rxd_a = 1'b0; wait_cyc(5); rxd_a = 1'b1; wait_cyc(30);
    send_byte(0, 8'h12, 1'b1);
    send_byte(0, 8'h34, 1'b1);
    send_byte(0, 8'h56, 1'b1);
    send_byte(0, 8'hAA, 1'b1);
    wait_cyc(48);
    check("glitch_valid", fv_cnt - fv0, 1);
    check("glitch_no_err", fe_cnt - fe0, 0);
    check("glitch_fields", {adr_a, mode_a, d_a}, {2'd1, 6'h01, 24'h123456});

    // reset in the middle of the fourth byte
    fv0 = fv_cnt;
    fe0 = fe_cnt;
    send_byte(0, 8'hFF, 1'b1);
    send_byte(0, 8'h01, 1'b1);
    send_byte(0, 8'h02, 1'b1);
    rxd_a = 1'b0; wait_cyc(int'(BPS_A));
    rxd_a = 1'b1; wait_cyc(int'(BPS_A));
    rxd_a = 1'b0; wait_cyc(int'(BPS_A));
    sys_rst = 1'b1;
    rxd_a   = 1'b1;
    wait_cyc(5);
    check("midrst_outputs", {fv_a, fe_a, adr_a, mode_a, d_a}, 32'h0);
    sys_rst = 1'b0;
    wait_cyc(600);
    check("midrst_no_pulses", (fv_cnt - fv0) + (fe_cnt - fe0), 0);
    check("midrst_outputs_after", {adr_a, mode_a, d_a}, 32'h0);
    frm = '{8'hFF, 8'h03, 8'h05, 8'h0A, 8'h0B, 8'h0C, 8'hAA};
    for (int j = 0; j < 7; j++) send_byte(0, frm[j], 1'b1);
    wait_cyc(48);
    check("midrst_next_valid", fv_cnt - fv0, 1);
    check("midrst_next_fields", {adr_a, mode_a, d_a}, {2'd3, 6'h05, 24'h0A0B0C});

    // default-parameter instance, full-rate frame
    frm = '{8'hFF, 8'h02, 8'h15, 8'h12, 8'h34, 8'h56, 8'hAA};
    for (int j = 0; j < 7; j++) send_byte(1, frm[j], 1'b1);
    wait_cyc(2 * BPS_B);
    check("default_valid", fv_cnt_b, 1);
    check("default_no_err", fe_cnt_b, 0);
    check("default_fields", {adr_b, mode_b, d_b}, {2'd2, 6'h15, 24'h123456});

    check("invariants", inv_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
